// File: rtl/io_bus_controller_if.sv
// io_bus_controller_if
//   Requester and device handshake signals of the shared IO port controller.
//   Ports 0 (CPU) and 1 (debug/loader) issue level requests and get back
//   read data, a one-cycle done pulse and an error flag. io_read/io_write
//   are the strobes to the device and ioack is the device acknowledge.
//   The 16-bit bidirectional data bus is not part of the interface; it is
//   a plain inout on the controller.
//   Modports:
//     slave  - the controller (consumes requests and ioack, drives results
//              and strobes)
//     master - the environment (requesters plus device ack)
interface io_bus_controller_if;
  logic        req0_rd;
  logic        req0_wr;
  logic [15:0] req0_wdata;
  logic [15:0] rdata0;
  logic        done0;
  logic        err0;
  logic        req1_rd;
  logic        req1_wr;
  logic [15:0] req1_wdata;
  logic [15:0] rdata1;
  logic        done1;
  logic        err1;
  logic        io_read;
  logic        io_write;
  logic        ioack;

  modport slave (
    input  req0_rd, req0_wr, req0_wdata, req1_rd, req1_wr, req1_wdata, ioack,
    output rdata0, done0, err0, rdata1, done1, err1, io_read, io_write
  );

  modport master (
    output req0_rd, req0_wr, req0_wdata, req1_rd, req1_wr, req1_wdata, ioack,
    input  rdata0, done0, err0, rdata1, done1, err1, io_read, io_write
  );
endinterface

// File: rtl/io_bus_controller.sv
// io_bus_controller
//   Sequences four-phase strobe/ack cycles on the shared 16-bit IO port for
//   two requesters with round-robin arbitration, owns the tristate data
//   driver, and returns read data plus a one-cycle done pulse per port.
//   Ports:
//     clk   - system clock, rising edge
//     rst   - synchronous active-high reset
//     bus   - io_bus_controller_if.slave: requests/results of ports 0 and 1,
//             io_read/io_write strobes, ioack from the device
//     data  - shared bidirectional bus, driven only during a write
//   Parameters:
//     TIMEOUT_CYCLES - cycles waited on either ack edge before aborting
//   Build option:
//     IOC_TIMEOUT_EN - when defined, a wait counter aborts a stalled
//                      transaction with done+err (read data = 16'hFFFF);
//                      when undefined err0/err1 are 0 and waits are unbounded.
module io_bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  io_bus_controller_if.slave  bus,
  inout  wire  [15:0]         data
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t                         state;
  logic [1:0]                     ack_sync;
  logic                           ack_s;
  logic                           gnt;       // granted port id
  logic                           gnt_wr;    // granted op is a write
  logic                           last_gnt;  // port granted most recently
  logic [15:0]                    wdata_q;
  logic                           drive_en;
  logic                           io_rd_q;
  logic                           io_wr_q;
  logic [NUM_PORTS-1:0]           done_q;
  logic [NUM_PORTS-1:0][15:0]     rdata_q;
  logic [NUM_PORTS-1:0]           req_rd;
  logic [NUM_PORTS-1:0]           req_wr;
  logic [NUM_PORTS-1:0]           elig;
  logic [NUM_PORTS-1:0][15:0]     req_wdata;
  logic                           pick;

  assign req_rd    = {bus.req1_rd, bus.req0_rd};
  assign req_wr    = {bus.req1_wr, bus.req0_wr};
  assign req_wdata = {bus.req1_wdata, bus.req0_wdata};

  // A port whose done is high this cycle is still holding its request;
  // masking it keeps the same transaction from being served twice.
  assign elig = (req_rd | req_wr) & ~done_q;

  // Contention goes to the port not granted last.
  always_comb begin
    pick = 1'b0;
    if (elig[0] && elig[1]) pick = ~last_gnt;
    else if (elig[1])       pick = 1'b1;
  end

  // The synchroniser is deliberately outside reset: an ack still high from
  // an interrupted transaction must stay visible so IDLE waits for it to drop.
  always_ff @(posedge clk) ack_sync <= {ack_sync[0], bus.ioack};
  assign ack_s = ack_sync[1];

`ifdef IOC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0]     to_cnt;
  logic [NUM_PORTS-1:0] err_q;
  logic                 to_hit;
  // Counter is 0 on the first cycle of the state, so hitting the limit on
  // count TIMEOUT_CYCLES-1 puts the abort exactly TIMEOUT_CYCLES after entry.
  assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      gnt_wr   <= 1'b0;
      last_gnt <= 1'b1;
      wdata_q  <= '0;
      drive_en <= 1'b0;
      io_rd_q  <= 1'b0;
      io_wr_q  <= 1'b0;
      done_q   <= '0;
      rdata_q  <= '0;
`ifdef IOC_TIMEOUT_EN
      to_cnt   <= '0;
      err_q    <= '0;
`endif
    end else begin
      done_q <= '0;
`ifdef IOC_TIMEOUT_EN
      err_q  <= '0;
      to_cnt <= to_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if ((|elig) && !ack_s) begin
            gnt      <= pick;
            last_gnt <= pick;
            gnt_wr   <= req_wr[pick];
            wdata_q  <= req_wdata[pick];
            drive_en <= req_wr[pick];
            state    <= SETUP;
          end
        end
        SETUP: begin
          io_rd_q <= !gnt_wr;
          io_wr_q <= gnt_wr;
          state   <= STROBE;
`ifdef IOC_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        STROBE: begin
          if (ack_s) begin
            if (!gnt_wr) rdata_q[gnt] <= data;
            io_rd_q <= 1'b0;
            io_wr_q <= 1'b0;
            state   <= RELEASE;
`ifdef IOC_TIMEOUT_EN
            to_cnt  <= '0;
          end else if (to_hit) begin
            if (!gnt_wr) rdata_q[gnt] <= 16'hFFFF;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
            drive_en    <= 1'b0;
            done_q[gnt] <= 1'b1;
            err_q[gnt]  <= 1'b1;
            state       <= IDLE;
`endif
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            drive_en    <= 1'b0;
            done_q[gnt] <= 1'b1;
            state       <= IDLE;
`ifdef IOC_TIMEOUT_EN
          end else if (to_hit) begin
            if (!gnt_wr) rdata_q[gnt] <= 16'hFFFF;
            drive_en    <= 1'b0;
            done_q[gnt] <= 1'b1;
            err_q[gnt]  <= 1'b1;
            state       <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data         = drive_en ? wdata_q : 16'bz;
  assign bus.io_read  = io_rd_q;
  assign bus.io_write = io_wr_q;
  assign bus.rdata0   = rdata_q[0];
  assign bus.rdata1   = rdata_q[1];
  assign bus.done0    = done_q[0];
  assign bus.done1    = done_q[1];
`ifdef IOC_TIMEOUT_EN
  assign bus.err0     = err_q[0];
  assign bus.err1     = err_q[1];
`else
  assign bus.err0     = 1'b0;
  assign bus.err1     = 1'b0;
`endif
endmodule
